// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM encoding, the slice truth tables and a counter sizing helper.
package serial_adder_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 8;

    // Minterm sets of the single-bit slice, indexed by {a, b, cin}.
    // Sum is odd parity (1, 2, 4, 7); carry is majority (3, 5, 6, 7).
    localparam logic [7:0] FA_SUM_MINTERMS   = 8'b1001_0110;
    localparam logic [7:0] FA_CARRY_MINTERMS = 8'b1110_1000;

    // Bit counter width: $clog2(w), never below one bit
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder built from a 3-to-8 minterm decoder.
// Sum and carry are ORs of the decoded minterms selected by fixed masks.
module full_adder
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic carry_out
);

    logic [7:0] dec;

    // One-hot decode of the three input bits
    always_comb begin
        dec = 8'b0;
        unique case ({a, b, cin})
            3'd0: dec[0] = 1'b1;
            3'd1: dec[1] = 1'b1;
            3'd2: dec[2] = 1'b1;
            3'd3: dec[3] = 1'b1;
            3'd4: dec[4] = 1'b1;
            3'd5: dec[5] = 1'b1;
            3'd6: dec[6] = 1'b1;
            3'd7: dec[7] = 1'b1;
            default: dec = 8'b0;
        endcase
    end

    assign s         = |(dec & FA_SUM_MINTERMS);
    assign carry_out = |(dec & FA_CARRY_MINTERMS);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder slice sequenced LSB first.
// Operands enter on a valid/ready accept; the result leaves on valid/ready.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_t state;
    sa_state_t state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_shift;
    logic             carry;
    logic             carry_prev;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;

    full_adder u_fa (
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .cin       (carry),
        .s         (fa_s),
        .carry_out (fa_co)
    );

    assign accept   = (state == IDLE) && start_valid;
    assign last_bit = (state == RUN) && (cnt == CNT_LAST);

    // New slice sum enters at the MSB so the LSB lands at bit 0 last
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_shift = fa_s;
        end else begin : g_wn
            assign sum_shift = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        state_nx     = state;
        start_ready  = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                if (result_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand load on accept, one bit of addition per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            carry      <= 1'b0;
            carry_prev <= 1'b0;
            cnt        <= '0;
        end else if (accept) begin
            a_sh       <= a;
            b_sh       <= b;
            carry      <= c_in;
            carry_prev <= 1'b0;
            cnt        <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_shift;
            carry  <= fa_co;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                carry_prev <= carry;
            end
        end
    end

    // Result fields come straight from registers
    assign sum   = sum_sh;
    assign c_out = carry;
    assign ovf   = carry_prev ^ carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl.
// Exercises an 8-bit build and a 1-bit build side by side.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         busy;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    logic         w1_start_valid = 1'b0;
    logic         w1_start_ready;
    logic [0:0]   w1_a = '0;
    logic [0:0]   w1_b = '0;
    logic         w1_c_in = 1'b0;
    logic         w1_busy;
    logic         w1_result_valid;
    logic         w1_result_ready = 1'b0;
    logic [0:0]   w1_sum;
    logic         w1_c_out;
    logic         w1_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .c_in         (c_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum          (sum),
        .c_out        (c_out),
        .ovf          (ovf)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut_w1 (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (w1_start_valid),
        .start_ready  (w1_start_ready),
        .a            (w1_a),
        .b            (w1_b),
        .c_in         (w1_c_in),
        .busy         (w1_busy),
        .result_valid (w1_result_valid),
        .result_ready (w1_result_ready),
        .sum          (w1_sum),
        .c_out        (w1_c_out),
        .ovf          (w1_ovf)
    );

    // Issue one operation and count clocks (accept edge = 1) until result_valid
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, output int lat);
        @(posedge clk);
        #1;
        a = ta;
        b = tb;
        c_in = tc;
        start_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        start_valid = 1'b0;
        a = ~ta;
        b = ~tb;
        c_in = ~tc;
        while (!result_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({start_ready, busy, result_valid, c_out, ovf} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 10000",
                     {start_ready, busy, result_valid, c_out, ovf});
        end
        checks++;
        if (sum !== 8'h00) begin
            errors++;
            $display("FAIL reset_sum: got %h want 00", sum);
        end
        checks++;
        if ({w1_start_ready, w1_busy, w1_result_valid, w1_sum, w1_c_out, w1_ovf}
            !== 6'b100000) begin
            errors++;
            $display("FAIL reset_w1: got %b want 100000",
                     {w1_start_ready, w1_busy, w1_result_valid,
                      w1_sum, w1_c_out, w1_ovf});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready_ignored: got rdy=%b vld=%b want 1 0",
                     start_ready, result_valid);
        end
    endtask

    task automatic test_add(input string name, input logic [W-1:0] ta,
                            input logic [W-1:0] tb, input logic tc,
                            input logic [W-1:0] exp_s, input logic exp_c,
                            input logic exp_o, input int exp_lat);
        int lat;
        do_op(ta, tb, tc, lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (sum !== exp_s) begin
            errors++;
            $display("FAIL %s sum: got %h want %h", name, sum, exp_s);
        end
        checks++;
        if ({c_out, ovf} !== {exp_c, exp_o}) begin
            errors++;
            $display("FAIL %s c_out/ovf: got %b%b want %b%b",
                     name, c_out, ovf, exp_c, exp_o);
        end
        checks++;
        if (start_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done_ctrl: got rdy=%b busy=%b want 0 1",
                     name, start_ready, busy);
        end
        release_result();
        checks++;
        if ({start_ready, busy, result_valid} !== 3'b100) begin
            errors++;
            $display("FAIL %s back_idle: got %b want 100",
                     name, {start_ready, busy, result_valid});
        end
    endtask

    task automatic test_add_basic();
        test_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 9);
    endtask

    task automatic test_back_to_back();
        test_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 9);
        test_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 9);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        do_op(8'h80, 8'h80, 1'b0, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL bp_latency: got %0d want 9", lat);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (result_valid !== 1'b1 || start_ready !== 1'b0 ||
                sum !== 8'h00 || c_out !== 1'b1 || ovf !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold cyc%0d: got v=%b r=%b s=%h c=%b o=%b want 1 0 00 1 1",
                         i, result_valid, start_ready, sum, c_out, ovf);
            end
            if (i == 2) begin
                a = 8'h11;
                b = 8'h22;
                start_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            start_valid = 1'b0;
        end
        checks++;
        if (bad != 0) begin
            errors++;
        end
        release_result();
        checks++;
        if ({start_ready, busy, result_valid} !== 3'b100) begin
            errors++;
            $display("FAIL bp_no_accept: got %b want 100",
                     {start_ready, busy, result_valid});
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        @(posedge clk);
        #1;
        a = 8'h5A;
        b = 8'h3C;
        c_in = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || sum === 8'h00) begin
            errors++;
            $display("FAIL abort_pre: got busy=%b sum=%h want busy=1 sum!=00",
                     busy, sum);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({start_ready, busy, result_valid, c_out, ovf} !== 5'b10000 ||
            sum !== 8'h00) begin
            errors++;
            $display("FAIL abort_reset: got %b sum=%h want 10000 sum=00",
                     {start_ready, busy, result_valid, c_out, ovf}, sum);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (result_valid !== 1'b0) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen);
        end
        test_add("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 9);
    endtask

    task automatic test_width1();
        int lat;
        @(posedge clk);
        #1;
        w1_a = 1'b1;
        w1_b = 1'b1;
        w1_c_in = 1'b1;
        w1_start_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        w1_start_valid = 1'b0;
        w1_a = 1'b0;
        w1_b = 1'b0;
        w1_c_in = 1'b0;
        while (!w1_result_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL w1_latency: got %0d want 2", lat);
        end
        checks++;
        if ({w1_sum, w1_c_out, w1_ovf} !== 3'b110) begin
            errors++;
            $display("FAIL w1_result: got s=%b c=%b o=%b want 1 1 0",
                     w1_sum, w1_c_out, w1_ovf);
        end
        w1_result_ready = 1'b1;
        @(posedge clk);
        #1;
        w1_result_ready = 1'b0;
        checks++;
        if ({w1_start_ready, w1_busy, w1_result_valid} !== 3'b100) begin
            errors++;
            $display("FAIL w1_back_idle: got %b want 100",
                     {w1_start_ready, w1_busy, w1_result_valid});
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
